// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and data-memory bus bundle for mem_access_unit
//
// Ports (signals):
//   req_valid/req_ready/req_write/req_funct3/req_addr/req_wdata : pipeline request
//   resp_valid/resp_rdata/resp_misaligned                        : one-cycle response
//   mem_address/mem_write_data/mem_read/mem_write/mem_read_data  : data memory bus
// master = the access unit, slave = pipeline + memory side.
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_misaligned;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] mem_read_data;

  modport master (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_misaligned,
           mem_address, mem_write_data, mem_read, mem_write
  );

  modport slave (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned,
           mem_address, mem_write_data, mem_read, mem_write
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit driving a word-wide data memory
//
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_access_unit_if.master (request, response and memory bus)
module mem_access_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 1
) (
  input logic               clk,
  input logic               rst_n,
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           wdata_lo_q;
  logic                  write_q;
  logic [2:0]            funct3_q;
  logic [3:0]            cnt_q;
  logic                  mis_q;
  // Holds the word to write (stores) or the extended load result (loads).
  logic [DATA_WIDTH-1:0] word_q;

  logic                  accept;
  logic                  fault;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic                  sx;
  logic [DATA_WIDTH-1:0] load_word;
  logic [DATA_WIDTH-1:0] merged;

  assign accept = (state_q == IDLE) && bus.req_valid;

  always_comb begin
    fault = 1'b0;
    case (bus.req_funct3)
      3'b000:  fault = 1'b0;
      3'b001:  fault = bus.req_addr[0];
      3'b010:  fault = |bus.req_addr[1:0];
      3'b100:  fault = bus.req_write;
      3'b101:  fault = bus.req_write | bus.req_addr[0];
      default: fault = 1'b1;
    endcase
  end

  // Big-endian lane order inside the word: lower address = more significant byte.
  always_comb begin
    lane_b = 8'h00;
    case (addr_q[1:0])
      2'd0: lane_b = bus.mem_read_data[31:24];
      2'd1: lane_b = bus.mem_read_data[23:16];
      2'd2: lane_b = bus.mem_read_data[15:8];
      2'd3: lane_b = bus.mem_read_data[7:0];
      default: lane_b = 8'h00;
    endcase
    lane_h = addr_q[1] ? bus.mem_read_data[15:0] : bus.mem_read_data[31:16];
    sx     = ~funct3_q[2];
    case (funct3_q[1:0])
      2'b00:   load_word = {{24{sx & lane_b[7]}}, lane_b};
      2'b01:   load_word = {{16{sx & lane_h[15]}}, lane_h};
      default: load_word = bus.mem_read_data;
    endcase
  end

  // Only SB and SH pass through RD as stores, so anything not SB is SH.
  always_comb begin
    merged = bus.mem_read_data;
    if (funct3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'd0: merged[31:24] = wdata_lo_q[7:0];
        2'd1: merged[23:16] = wdata_lo_q[7:0];
        2'd2: merged[15:8]  = wdata_lo_q[7:0];
        2'd3: merged[7:0]   = wdata_lo_q[7:0];
        default: merged = bus.mem_read_data;
      endcase
    end else if (addr_q[1]) begin
      merged[15:0] = wdata_lo_q;
    end else begin
      merged[31:16] = wdata_lo_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (fault)                                           state_d = RESP;
          else if (bus.req_write && bus.req_funct3 == 3'b010)  state_d = WR;
          else                                                 state_d = RD;
        end
      end
      RD:      if (cnt_q == 4'd0) state_d = write_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wdata_lo_q <= '0;
      write_q    <= 1'b0;
      funct3_q   <= '0;
      cnt_q      <= '0;
      mis_q      <= 1'b0;
      word_q     <= '0;
    end else if (accept) begin
      addr_q     <= bus.req_addr;
      wdata_lo_q <= bus.req_wdata[15:0];
      write_q    <= bus.req_write;
      funct3_q   <= bus.req_funct3;
      cnt_q      <= 4'(WAIT_CYCLES);
      mis_q      <= fault;
      word_q     <= bus.req_wdata;
    end else if (state_q == RD) begin
      if (cnt_q == 4'd0) word_q <= write_q ? merged : load_word;
      else               cnt_q  <= cnt_q - 4'd1;
    end
  end

  always_comb begin
    bus.req_ready       = 1'b0;
    bus.resp_valid      = 1'b0;
    bus.resp_rdata      = '0;
    bus.resp_misaligned = 1'b0;
    bus.mem_address     = '0;
    bus.mem_write_data  = '0;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    case (state_q)
      IDLE: bus.req_ready = rst_n;
      RD: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = {addr_q[ADDR_WIDTH-1:2], 2'b00};
      end
      WR: begin
        bus.mem_write      = 1'b1;
        bus.mem_address    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        bus.mem_write_data = word_q;
      end
      RESP: begin
        bus.resp_valid      = 1'b1;
        bus.resp_misaligned = mis_q;
        bus.resp_rdata      = (write_q || mis_q) ? '0 : word_q;
      end
      default: bus.req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_CYCLES(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'd0;
  logic [31:0] pl_data = 32'd0;

  assign bus.mem_read_data = mem[bus.mem_address[9:2]];

  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_address[9:2]] <= bus.mem_write_data;
    else if (pl_en)    mem[pl_idx] <= pl_data;
  end

  int rd_cnt = 0, wr_cnt = 0, resp_cnt = 0, overlap = 0;
  logic [31:0] last_rd_addr = 32'd0, last_wr_data = 32'd0;

  always @(negedge clk) begin
    if (bus.mem_read) begin rd_cnt++; last_rd_addr = bus.mem_address; end
    if (bus.mem_write) begin wr_cnt++; last_wr_data = bus.mem_write_data; end
    if (bus.resp_valid) resp_cnt++;
    if (bus.mem_read && bus.mem_write) overlap++;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge of the response cycle.
  task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rdata, output logic mis,
                         output int lat, output int nrd, output int nwr);
    int rd0, wr0;
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    chk("ready_before_req", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = d;
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = -1; rdata = 'x; mis = 1'bx;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = c; rdata = bus.resp_rdata; mis = bus.resp_misaligned;
        break;
      end
    end
    nrd = rd_cnt - rd0;
    nwr = wr_cnt - wr0;
  endtask

  logic [31:0] rdata;
  logic        mis;
  int          lat, nrd, nwr, wr0, resp0, r1, rdy;

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;

    #1;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
    chk("rst_mem_address", bus.mem_address, 32'd0);

    preload(8'd64, 32'h11223344);
    preload(8'd128, 32'h80FF1234);
    preload(8'd192, 32'h00000000);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);

    run_req(1'b0, 3'b010, 32'h100, 32'd0, rdata, mis, lat, nrd, nwr);
    chk("lw_lat", 32'(lat), 32'd3);
    chk("lw_rdata", rdata, 32'h11223344);
    chk("lw_mis", {31'd0, mis}, 32'd0);
    chk("lw_nrd", 32'(nrd), 32'd2);
    chk("lw_nwr", 32'(nwr), 32'd0);
    chk("lw_addr", last_rd_addr, 32'h100);

    run_req(1'b0, 3'b000, 32'h200, 32'd0, rdata, mis, lat, nrd, nwr);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    chk("lb_lat", 32'(lat), 32'd3);
    run_req(1'b0, 3'b100, 32'h201, 32'd0, rdata, mis, lat, nrd, nwr);
    chk("lbu_rdata", rdata, 32'h000000FF);
    run_req(1'b0, 3'b001, 32'h202, 32'd0, rdata, mis, lat, nrd, nwr);
    chk("lh_rdata", rdata, 32'h00001234);
    run_req(1'b0, 3'b101, 32'h200, 32'd0, rdata, mis, lat, nrd, nwr);
    chk("lhu_rdata", rdata, 32'h000080FF);
    chk("lhu_addr", last_rd_addr, 32'h200);

    run_req(1'b1, 3'b000, 32'h101, 32'hAABBCCDD, rdata, mis, lat, nrd, nwr);
    chk("sb_lat", 32'(lat), 32'd4);
    chk("sb_nwr", 32'(nwr), 32'd1);
    chk("sb_nrd", 32'(nrd), 32'd2);
    chk("sb_wdata", last_wr_data, 32'h11DD3344);
    chk("sb_rdata", rdata, 32'd0);
    chk("sb_mis", {31'd0, mis}, 32'd0);
    run_req(1'b0, 3'b010, 32'h100, 32'd0, rdata, mis, lat, nrd, nwr);
    chk("lw_after_sb", rdata, 32'h11DD3344);

    run_req(1'b1, 3'b001, 32'h102, 32'h0000BEEF, rdata, mis, lat, nrd, nwr);
    chk("sh_lat", 32'(lat), 32'd4);
    chk("sh_wdata", last_wr_data, 32'h11DDBEEF);
    run_req(1'b0, 3'b010, 32'h100, 32'd0, rdata, mis, lat, nrd, nwr);
    chk("lw_after_sh", rdata, 32'h11DDBEEF);

    run_req(1'b0, 3'b010, 32'h102, 32'd0, rdata, mis, lat, nrd, nwr);
    chk("lw_mis_lat", 32'(lat), 32'd1);
    chk("lw_mis_flag", {31'd0, mis}, 32'd1);
    chk("lw_mis_rdata", rdata, 32'd0);
    chk("lw_mis_strobes", 32'(nrd + nwr), 32'd0);
    run_req(1'b0, 3'b001, 32'h103, 32'd0, rdata, mis, lat, nrd, nwr);
    chk("lh_mis_lat", 32'(lat), 32'd1);
    chk("lh_mis_flag", {31'd0, mis}, 32'd1);
    chk("lh_mis_strobes", 32'(nrd + nwr), 32'd0);
    run_req(1'b1, 3'b100, 32'h100, 32'h12345678, rdata, mis, lat, nrd, nwr);
    chk("sbu_fault_flag", {31'd0, mis}, 32'd1);
    chk("sbu_fault_nwr", 32'(nwr), 32'd0);
    run_req(1'b0, 3'b011, 32'h100, 32'd0, rdata, mis, lat, nrd, nwr);
    chk("undef_f3_flag", {31'd0, mis}, 32'd1);
    chk("undef_f3_lat", 32'(lat), 32'd1);
    chk("mem_unchanged_after_faults", mem[64], 32'h11DDBEEF);

    // Reset while an SB sits in RD.
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    wr0 = wr_cnt; resp0 = resp_cnt;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h100; bus.req_wdata = 32'h000000AA;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("pre_abort_mem_read", {31'd0, bus.mem_read}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_mem_read", {31'd0, bus.mem_read}, 32'd0);
    chk("abort_mem_address", bus.mem_address, 32'd0);
    chk("abort_req_ready", {31'd0, bus.req_ready}, 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_write", 32'(wr_cnt - wr0), 32'd0);
    chk("abort_no_resp", 32'(resp_cnt - resp0), 32'd0);
    rst_n = 1'b1;
    #1 chk("abort_release_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("abort_mem_unchanged", mem[64], 32'h11DDBEEF);
    @(negedge clk);
    run_req(1'b0, 3'b010, 32'h100, 32'd0, rdata, mis, lat, nrd, nwr);
    chk("lw_after_abort", rdata, 32'h11DDBEEF);
    chk("lw_after_abort_lat", 32'(lat), 32'd3);

    // req_valid held high across SW then LW.
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h300; bus.req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 bus.req_write = 1'b0; bus.req_wdata = 32'd0;
    r1 = -1; rdy = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.resp_valid && r1 < 0) r1 = c;
      if (bus.req_ready) begin rdy = c; break; end
    end
    chk("b2b_sw_resp_cycle", 32'(r1), 32'd2);
    chk("b2b_ready_cycle", 32'(rdy), 32'd3);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = -1; rdata = 'x;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin lat = c; rdata = bus.resp_rdata; break; end
    end
    chk("b2b_lw_lat", 32'(lat), 32'd3);
    chk("b2b_lw_rdata", rdata, 32'hCAFEF00D);
    chk("no_rw_overlap", 32'(overlap), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage initiator that drives the byte-addressable data memory.
- Accepts one load/store request at a time from the pipeline and converts it into word-aligned memory reads and writes.
- Performs byte/halfword lane extraction with sign/zero extension, read-modify-write for sub-word stores, and misalignment detection.
- Returns a one-cycle response pulse.

Parameters:
- ADDR_WIDTH, 32, byte-address width of request and memory address.
- DATA_WIDTH, 32, data width. Fixed at 32 for lane logic.
- WAIT_CYCLES, 1, extra cycles mem_read is held before mem_read_data is sampled (covers memory access delay). Legal range 0-15.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU. BU/HU are valid for loads only.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  extended load data. 0 for stores and faults.
- resp_misaligned  out  1  fault flag, valid with resp_valid.
- mem_address  out  ADDR_WIDTH  word address {addr[31:2],2'b00}.
- mem_write_data  out  DATA_WIDTH  full word to write.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe. Memory writes on the rising edge where this is high.
- mem_read_data  in  DATA_WIDTH  memory word.

Behaviour:
- Lane order:
  - Byte at offset k (addr[1:0]) occupies word bits [31-8k -: 8].
  - Halfword at offset 0 occupies [31:16]; at offset 2 occupies [15:0].
  - The lower-address byte is the most significant byte.
- Reset: state IDLE. req_ready=0 while rst_n low. All other outputs 0 immediately; mem_write drops asynchronously. Reset mid-operation aborts the operation with no response. After release, IDLE and req_ready=1.
- FSM states: IDLE, RD, WR, RESP.
- IDLE:
  - req_ready=1; memory outputs 0.
  - On req_valid, latch addr/wdata/write/funct3.
  - Fault condition: H/HU with addr[0]=1, W with addr[1:0]!=0, undefined funct3, or BU/HU on a store. Fault -> RESP with misaligned=1, no memory strobe.
  - Else store W -> WR with merged word = req_wdata.
  - Else (any load, or SB/SH) -> RD with wait counter = WAIT_CYCLES.
- RD:
  - mem_read=1 and mem_address stable for WAIT_CYCLES+1 cycles. Counter decrements each cycle.
  - On the cycle with counter=0, capture mem_read_data.
  - Load -> RESP with extracted lane: B/H sign-extended, BU/HU zero-extended, W unchanged.
  - Store -> WR with captured word, target lane replaced by req_wdata[7:0] (SB) or req_wdata[15:0] (SH).
- WR: mem_write=1 for exactly one cycle with mem_address and merged mem_write_data; mem_read=0 -> RESP.
- RESP: resp_valid=1 for exactly one cycle with resp_rdata/resp_misaligned; req_ready=0 -> IDLE.
- req_ready is 1 only in IDLE. Back-to-back requests are accepted no sooner than the cycle after RESP. No response backpressure.
- Latency (cycles from accept edge to resp_valid):
  - fault: 1
  - SW: 2
  - load: WAIT_CYCLES+2
  - SB/SH: WAIT_CYCLES+3
- mem_read and mem_write are never high in the same cycle.
- mem_address, mem_write_data and resp_rdata are 0 outside their active states.

Test Plan:
- Memory word 0x100 = 0x11223344, WAIT_CYCLES=1: LW 0x100 -> resp_valid at cycle 3, resp_rdata=0x11223344, misaligned=0; mem_read high exactly 2 cycles, mem_address=0x100.
- Word 0x200 = 0x80FF1234:
  - LB 0x200 -> 0xFFFFFF80
  - LBU 0x201 -> 0x000000FF
  - LH 0x202 -> 0x00001234
  - LHU 0x200 -> 0x000080FF
- SB 0x101 with req_wdata=0xAABBCCDD on word 0x11223344 -> one mem_write cycle with mem_write_data=0x11DD3344; subsequent LW 0x100 returns 0x11DD3344. SH 0x102 data 0xBEEF -> word 0x11DDBEEF.
- LW 0x102 and LH 0x103 -> resp_valid at cycle 1, misaligned=1, rdata=0; mem_read/mem_write never asserted; memory unchanged.
- rst_n low during RD of an SB -> outputs 0 immediately, no mem_write, no resp_valid; memory word unchanged. After release, req_ready=1 and LW completes normally.
- req_valid held high across two requests (SW 0x300=0xCAFEF00D, then LW 0x300) -> second accepted only after first resp_valid; LW returns 0xCAFEF00D.
